// File: rtl/qosc_pkg.sv
// qosc_pkg -- shared definitions for the quadrature-oscillator power monitor.
//   W_DEF           default I/Q sample width
//   POWER_SHIFT_DEF default left shift from power code to target magnitude
//   TOL_DEF         default in-tolerance window on |err|
//   state_t / IDLE, SQ_RE, SQ_IM, CMP  monitor FSM encoding
package qosc_pkg;

   localparam int W_DEF           = 8;
   localparam int POWER_SHIFT_DEF = 4;
   localparam int TOL_DEF         = 64;

   typedef logic [1:0] state_t;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SQ_RE = 2'd1;
   localparam logic [1:0] SQ_IM = 2'd2;
   localparam logic [1:0] CMP   = 2'd3;

endpackage

// File: rtl/qosc_seq_squarer.sv
// qosc_seq_squarer -- iterative shift-add squarer for a signed W-bit operand.
// The operand magnitude is squared one multiplier bit per clock.
//   clk, rst_n  clock, synchronous active-low reset
//   start       load operand and begin (overrides any run in progress)
//   operand     signed W-bit value to square
//   done        high during the cycle whose closing edge performs the last
//               add; result is final from the following cycle on
//   result      2W-bit unsigned accumulator (operand^2 once finished)
module qosc_seq_squarer #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   operand,
   output logic           done,
   output logic [2*W-1:0] result
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   typedef logic [CW-1:0] cnt_t;

   logic [W-1:0]   abs_op;
   logic [2*W-1:0] mcand_reg;
   logic [W-1:0]   mplier_reg;
   logic [2*W-1:0] acc_reg;
   cnt_t           cnt_reg;
   logic           busy_reg;

   // Unary minus wraps -2^(W-1) onto itself, which read unsigned is the
   // correct magnitude 2^(W-1).
   assign abs_op = operand[W-1] ? -operand : operand;

   assign done   = busy_reg && (cnt_reg == cnt_t'(W - 1));
   assign result = acc_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
      end else if (start) begin
         mcand_reg  <= {{W{1'b0}}, abs_op};
         mplier_reg <= abs_op;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b1;
      end else if (busy_reg) begin
         if (mplier_reg[0])
            acc_reg <= acc_reg + mcand_reg;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + cnt_t'(1);
         if (done)
            busy_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/qosc_power_monitor.sv
// qosc_power_monitor -- measures oscillator output power per I/Q sample.
// Each accepted sample is squared (re^2 + im^2) on one shared sequential
// squarer, compared with a programmed target and reported with flags.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   sample handshake; accu_re, accu_im, power latched on accept
//   out_valid/out_ready result handshake; result fields held until taken
//   mag_sq              re^2 + im^2 (unsigned, 2W bits)
//   err                 mag_sq - (power << POWER_SHIFT), signed 2W+1 bits
//   above/below/in_tol  err > TOL / err < -TOL / |err| <= TOL (only with out_valid)
//   peak, clr_peak      running maximum of mag_sq and its clear
//   drop_cnt            saturating count of samples offered while not ready
module qosc_power_monitor
   import qosc_pkg::*;
#(
   parameter int W           = W_DEF,
   parameter int POWER_SHIFT = POWER_SHIFT_DEF,
   parameter int TOL         = TOL_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   accu_re,
   input  logic [W-1:0]   accu_im,
   input  logic [7:0]     power,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] mag_sq,
   output logic [2*W:0]   err,
   output logic           above,
   output logic           below,
   output logic           in_tol,
   output logic [2*W-1:0] peak,
   input  logic           clr_peak,
   output logic [7:0]     drop_cnt
);

   typedef logic signed [2*W:0] err_t;

   localparam err_t TOL_POS = err_t'(TOL);
   localparam err_t TOL_NEG = -TOL_POS;

   state_t         state_reg;
   logic           im_launch_reg;
   logic [W-1:0]   im_reg;
   logic [7:0]     power_reg;
   logic [2*W-1:0] re_sq_reg;
   logic           out_valid_reg;
   logic [2*W-1:0] mag_reg;
   logic [2*W:0]   err_reg;
   logic           above_reg;
   logic           below_reg;
   logic           in_tol_reg;
   logic [2*W-1:0] peak_reg;
   logic [7:0]     drop_reg;

   logic           accept;
   logic           out_take;
   logic           sq_start;
   logic [W-1:0]   sq_operand;
   logic           sq_done;
   logic [2*W-1:0] sq_result;
   logic [2*W-1:0] mag_calc;
   logic [2*W:0]   target;
   err_t           err_calc;

   // rst_n gates ready so nothing is accepted or counted while held in reset.
   assign in_ready = rst_n && (state_reg == IDLE) && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_take = out_valid_reg && out_ready;

   // The re run is launched straight from the accept edge; the im run is
   // launched one cycle after re finishes, so re^2 can be saved first.
   assign sq_start   = accept || im_launch_reg;
   assign sq_operand = accept ? accu_re : im_reg;

   qosc_seq_squarer #(.W(W)) u_squarer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (sq_start),
      .operand (sq_operand),
      .done    (sq_done),
      .result  (sq_result)
   );

   // Valid only in CMP, where the squarer holds the finished im^2.
   assign mag_calc = re_sq_reg + sq_result;
   assign target   = {{(2*W+1-8){1'b0}}, power_reg} << POWER_SHIFT;
   assign err_calc = $signed({1'b0, mag_calc}) - $signed(target);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         im_launch_reg <= 1'b0;
         im_reg        <= '0;
         power_reg     <= '0;
         re_sq_reg     <= '0;
         out_valid_reg <= 1'b0;
         mag_reg       <= '0;
         err_reg       <= '0;
         above_reg     <= 1'b0;
         below_reg     <= 1'b0;
         in_tol_reg    <= 1'b0;
         peak_reg      <= '0;
         drop_reg      <= '0;
      end else begin
         im_launch_reg <= 1'b0;

         if (in_valid && !in_ready && (drop_reg != 8'hFF))
            drop_reg <= drop_reg + 8'd1;

         if (out_take) begin
            out_valid_reg <= 1'b0;
            above_reg     <= 1'b0;
            below_reg     <= 1'b0;
            in_tol_reg    <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  im_reg    <= accu_im;
                  power_reg <= power;
                  state_reg <= SQ_RE;
               end
            end
            SQ_RE: begin
               if (sq_done) begin
                  im_launch_reg <= 1'b1;
                  state_reg     <= SQ_IM;
               end
            end
            SQ_IM: begin
               if (im_launch_reg)
                  re_sq_reg <= sq_result;
               else if (sq_done)
                  state_reg <= CMP;
            end
            CMP: begin
               out_valid_reg <= 1'b1;
               mag_reg       <= mag_calc;
               err_reg       <= err_calc;
               above_reg     <= (err_calc > TOL_POS);
               below_reg     <= (err_calc < TOL_NEG);
               in_tol_reg    <= (err_calc <= TOL_POS) && (err_calc >= TOL_NEG);
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase

         // A clear coinciding with CMP restarts the maximum at the new sample.
         if (state_reg == CMP) begin
            if (clr_peak || (mag_calc > peak_reg))
               peak_reg <= mag_calc;
         end else if (clr_peak) begin
            peak_reg <= '0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign mag_sq    = mag_reg;
   assign err       = err_reg;
   assign above     = above_reg;
   assign below     = below_reg;
   assign in_tol    = in_tol_reg;
   assign peak      = peak_reg;
   assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_qosc_power_monitor.sv
// tb_qosc_power_monitor -- self-checking bench for qosc_power_monitor.
// Directed cases from the power-monitor test plan followed by randomized
// samples, all checked against an arithmetic reference model.
module tb_qosc_power_monitor;

   localparam int W   = 8;
   localparam int PS  = 4;
   localparam int TOL = 64;
   localparam int LAT = 2 * W + 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   accu_re;
   logic [W-1:0]   accu_im;
   logic [7:0]     power;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] mag_sq;
   logic [2*W:0]   err;
   logic           above;
   logic           below;
   logic           in_tol;
   logic [2*W-1:0] peak;
   logic           clr_peak;
   logic [7:0]     drop_cnt;

   always #5 clk = ~clk;

   qosc_power_monitor #(.W(W), .POWER_SHIFT(PS), .TOL(TOL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .accu_re   (accu_re),
      .accu_im   (accu_im),
      .power     (power),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_sq    (mag_sq),
      .err       (err),
      .above     (above),
      .below     (below),
      .in_tol    (in_tol),
      .peak      (peak),
      .clr_peak  (clr_peak),
      .drop_cnt  (drop_cnt)
   );

   int     n_tests = 0;
   int     n_fail  = 0;

   // reference model state
   longint exp_mag;
   longint exp_err;
   longint exp_above;
   longint exp_below;
   longint exp_tol;
   longint peak_m;
   longint drop_m;

   task automatic check_val(input string tag, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic void predict(input logic [7:0] re, input logic [7:0] im,
                                   input logic [7:0] pw);
      int r;
      int i;
      r = int'($signed(re));
      i = int'($signed(im));
      exp_mag   = longint'(r * r + i * i);
      exp_err   = exp_mag - longint'(int'(pw) * (1 << PS));
      exp_above = (exp_err > TOL) ? 1 : 0;
      exp_below = (exp_err < -TOL) ? 1 : 0;
      exp_tol   = (exp_above == 0 && exp_below == 0) ? 1 : 0;
   endfunction

   function automatic void note_drop();
      if (drop_m < 255)
         drop_m++;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_in_ready"}, longint'(in_ready), 0);
      check_val({tag, "_flags"}, longint'({out_valid, above, below, in_tol}), 0);
      check_val({tag, "_mag_sq"}, longint'(mag_sq), 0);
      check_val({tag, "_err"}, longint'(err), 0);
      check_val({tag, "_peak"}, longint'(peak), 0);
      check_val({tag, "_drop"}, longint'(drop_cnt), 0);
   endtask

   // Called just after a negedge. A pending result is taken in the same
   // cycle as the new sample is accepted. Inputs are scrambled afterwards.
   task automatic launch(input logic [7:0] re, input logic [7:0] im, input logic [7:0] pw);
      logic pend;
      pend      = out_valid;
      out_ready = pend;
      #1;
      check_val("in_ready_at_launch", longint'(in_ready), 1);
      accu_re  = re;
      accu_im  = im;
      power    = pw;
      in_valid = 1'b1;
      predict(re, im, pw);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      accu_re   = 8'($urandom);
      accu_im   = 8'($urandom);
      power     = 8'($urandom);
      if (pend)
         check_val("old_result_taken", longint'(out_valid), 0);
      check_val("busy_not_ready", longint'(in_ready), 0);
   endtask

   task automatic wait_result(input bit clr_cmp, input bit rnd_drops);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         clr_peak = clr_cmp && (lat == LAT - 1);
         in_valid = rnd_drops && ($urandom_range(3) == 0);
         if (in_valid)
            note_drop();
         @(negedge clk);
         lat++;
      end
      clr_peak = 1'b0;
      in_valid = 1'b0;
      check_val("latency", longint'(lat), longint'(LAT));
      if (clr_cmp || exp_mag > peak_m)
         peak_m = exp_mag;
      check_val("mag_sq", longint'(mag_sq), exp_mag);
      check_val("err", longint'($signed(err)), exp_err);
      check_val("above", longint'(above), exp_above);
      check_val("below", longint'(below), exp_below);
      check_val("in_tol", longint'(in_tol), exp_tol);
      check_val("peak", longint'(peak), peak_m);
      check_val("drop_cnt", longint'(drop_cnt), drop_m);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("out_valid_cleared", longint'(out_valid), 0);
      check_val("flags_cleared", longint'({above, below, in_tol}), 0);
   endtask

   task automatic check_held();
      check_val("held_out_valid", longint'(out_valid), 1);
      check_val("held_mag_sq", longint'(mag_sq), exp_mag);
      check_val("held_err", longint'($signed(err)), exp_err);
   endtask

   task automatic pulse_clr_idle();
      clr_peak = 1'b1;
      @(negedge clk);
      clr_peak = 1'b0;
      peak_m   = 0;
      check_val("peak_cleared", longint'(peak), 0);
   endtask

   initial begin
      int seen;
      int k;
      rst_n     = 1'b0;
      in_valid  = 1'b1;    // offered during reset: must not count as drops
      out_ready = 1'b0;
      clr_peak  = 1'b0;
      accu_re   = '0;
      accu_im   = '0;
      power     = '0;
      peak_m    = 0;
      drop_m    = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("ready_after_reset", longint'(in_ready), 1);
      @(negedge clk);

      // directed test-plan cases
      launch(8'h20, 8'h00, 8'h40); wait_result(1'b0, 1'b0); consume();
      launch(8'h80, 8'h80, 8'h40); wait_result(1'b0, 1'b0); consume();
      launch(8'h00, 8'h00, 8'h40); wait_result(1'b0, 1'b0); consume();
      launch(8'h1F, 8'h00, 8'h40); wait_result(1'b0, 1'b0);

      // result held, three refused samples
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         #1;
         check_val("refused_not_ready", longint'(in_ready), 0);
         note_drop();
         @(negedge clk);
         in_valid = 1'b0;
         check_held();
         @(negedge clk);
      end
      check_val("drop_after_three", longint'(drop_cnt), 3);

      // output take and new accept in the same cycle
      launch(8'h20, 8'h00, 8'h40); wait_result(1'b0, 1'b0); consume();

      // peak clear, then clear coincident with CMP
      pulse_clr_idle();
      launch(8'h80, 8'h80, 8'h40); wait_result(1'b0, 1'b0); consume();
      launch(8'h20, 8'h00, 8'h40); wait_result(1'b1, 1'b0); consume();

      // reset five cycles after an accept discards the sample
      launch(8'h11, 8'h22, 8'h33);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_reset");
      rst_n  = 1'b1;
      peak_m = 0;
      drop_m = 0;
      seen   = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid)
            seen++;
      end
      check_val("no_result_after_reset", longint'(seen), 0);
      launch(8'hE0, 8'h20, 8'h80); wait_result(1'b0, 1'b0); consume();

      // randomized samples
      for (int n = 0; n < 40; n++) begin
         launch(8'($urandom), 8'($urandom), 8'($urandom));
         wait_result(($urandom_range(7) == 0), 1'b1);
         k = $urandom_range(3);
         for (int j = 0; j < k; j++) begin
            in_valid = ($urandom_range(1) == 1);
            if (in_valid)
               note_drop();
            @(negedge clk);
            in_valid = 1'b0;
            check_held();
         end
         if ($urandom_range(5) == 0)
            pulse_clr_idle();
         if ($urandom_range(1) == 1)
            consume();
      end
      if (out_valid)
         consume();

      // drop counter saturation
      launch(8'h05, 8'hFB, 8'h01); wait_result(1'b0, 1'b0);
      in_valid = 1'b1;
      for (int i = 0; i < 260; i++) begin
         note_drop();
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val("drop_saturated", longint'(drop_cnt), 255);
      check_held();
      consume();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
